stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the datapath MUX: NUM_CH input channels of WIDTH bits, each with a valid/ready handshake.
- The selected channel is routed through one output register stage.
- Two selection modes:
  - Fixed: the cntl port picks the channel.
  - Round-robin: an internal fair arbiter picks the channel.
- Used where several MIPS pipeline sources (ALU, memory, forwarding paths) compete for one registered destination bus.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 3, number of input channels, legal range 2..16.
- SEL_W, $clog2(NUM_CH), width of cntl and out_ch. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset; low forces reset state immediately.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = fixed select by cntl, 1 = round-robin.
- cntl  input  SEL_W  channel index in fixed mode; ignored in round-robin.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.
- sel_err  output  1  registered one-cycle pulse: fixed mode with cntl >= NUM_CH while any in_valid is high.

Behaviour:
- Reset (reset low, asynchronous):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- can_load = !out_valid || out_ready.
- Grant, combinational, at most one bit set:
  - Fixed mode: grant[cntl] = in_valid[cntl], only if cntl < NUM_CH. Otherwise no grant.
  - Round-robin: first i with in_valid[i]=1, searching circularly from last+1 mod NUM_CH up to last.
- in_ready[i] = grant[i] && can_load. Non-granted channels always see in_ready=0.
- Transfer: in_valid[i] && in_ready[i]. On the next clock edge:
  - out_data = channel i data, out_ch = i, out_valid = 1.
  - In round-robin mode, last = i.
- Pointer update:
  - last updates only on a transfer in round-robin mode.
  - last is unchanged in fixed mode, so switching back to round-robin resumes fairly.
- Output hold:
  - If out_valid && !out_ready, out_data, out_ch and out_valid hold. No input is accepted.
- Output drain:
  - If out_valid && out_ready and no transfer occurs this cycle, out_valid goes to 0 next cycle.
  - out_data and out_ch hold their last values.
- Latency and throughput:
  - Latency is 1 cycle from input acceptance to out_valid.
  - Throughput is 1 transfer per cycle while out_ready=1.
- Input stability:
  - Once in_valid[i] is asserted, the source must hold it and in_data until accepted.
  - The block does not require grant stability across cycles.
- Mode and cntl changes:
  - Both are sampled combinationally and take effect in the same cycle.
  - A change never corrupts a word already in the output register.
- Simultaneous events:
  - A drain and a new load in the same cycle gives back-to-back output, with out_valid staying 1.
- Reset mid-operation:
  - A word held in the output register is discarded.
  - Sources must re-present their data.
- sel_err:
  - Set next cycle if mode=0, cntl >= NUM_CH and |in_valid=1. Otherwise 0.
  - It does not stall any other activity.

Optional Feature:
- Macro: STREAM_MUX_COUNT_EN.
- When defined:
  - Adds output xfer_cnt [NUM_CH*16-1:0], one 16-bit counter per channel.
  - A counter increments by 1 on each accepted transfer from its channel.
  - Counters wrap 0xFFFF -> 0 and reset to 0 asynchronously.
  - Adds input cnt_clr (1 bit), which synchronously clears all counters. Clear wins over a simultaneous increment.
- When undefined: the port and the logic are absent. All other behaviour is identical.

Test Plan:
- Reset with out_valid=1 pending, reset pulsed low mid-cycle -> out_valid=0 and out_data=0 immediately, without a clock edge; after release, the first round-robin grant goes to ch0.
- Fixed mode, NUM_CH=3, WIDTH=32, cntl=1, in_valid=3'b111, data ch0=0xA, ch1=0xB, ch2=0xC, out_ready=1 -> in_ready=3'b010; next cycle out_data=0xB, out_ch=1; continuous 0xB every cycle.
- Round-robin, all valid continuously, out_ready=1 -> out_ch sequence 0,1,2,0,1,2; with only ch2 valid -> out_ch=2 every cycle.
- Backpressure: out_ready=0 for 3 cycles after one load of 0x55 -> out_valid=1 and out_data=0x55 held; in_ready=0 throughout; out_ready=1 -> next word follows with no bubble.
- Fixed mode, cntl=3 (>= NUM_CH=3), in_valid=3'b001 -> in_ready=0, sel_err=1 the next cycle, out_valid falls after drain; mode=1 -> ch0 accepted.
- STREAM_MUX_COUNT_EN defined: 5 ch1 transfers then cnt_clr coincident with a 6th transfer -> counter reads 5 before the clear and 0 after; preload 0xFFFF plus one transfer -> 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-channel valid/ready stream multiplexer with a single
// registered output stage. The channel is chosen either by the cntl port
// (fixed mode) or by a fair round-robin arbiter (mode = 1).
// Optional feature macro: STREAM_MUX_COUNT_EN adds one 16-bit accepted-transfer
// counter per channel (xfer_cnt) with a synchronous clear input (cnt_clr).
module stream_mux_rr #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 3,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        cntl,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    sel_err
`ifdef STREAM_MUX_COUNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [NUM_CH*16-1:0]    xfer_cnt
`endif
);

  // Channel count in a width that can hold NUM_CH itself, so an out-of-range
  // cntl can be detected even when NUM_CH is not a power of two.
  localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
  // Pointer value after reset: the channel searched last, so channel 0 wins first.
  localparam logic [SEL_W-1:0] LAST_INIT  = SEL_W'(NUM_CH - 1);

  // Output register stage
  logic [WIDTH-1:0]  out_data_reg;
  logic              out_valid_reg;
  logic [SEL_W-1:0]  out_ch_reg;
  logic              sel_err_reg;
  logic              sel_err_next;

  // Round-robin pointer: index of the most recently served channel
  logic [SEL_W-1:0]  last_reg;

  // Selection datapath
  logic              can_load;
  logic              cntl_ok;
  logic [NUM_CH-1:0] fix_grant;
  logic [NUM_CH-1:0] hi_mask;
  logic [NUM_CH-1:0] req_hi;
  logic [NUM_CH-1:0] rr_grant_hi;
  logic [NUM_CH-1:0] rr_grant_all;
  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] grant;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  sel_data;
  logic              xfer;

  // The output register can take a new word when it is empty or being drained.
  assign can_load = !out_valid_reg || out_ready;

  // cntl addresses a real channel only when it is below NUM_CH.
  assign cntl_ok = ({1'b0, cntl} < NUM_CH_EXT);

  // Per-channel fixed-mode grant and the "strictly after last" mask used to
  // start the circular round-robin search just past the last served channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign fix_grant[gi] = cntl_ok && (cntl == SEL_W'(gi)) && in_valid[gi];
      assign hi_mask[gi]   = (SEL_W'(gi) > last_reg);
    end
  endgenerate

  // Circular search from last+1: look first at requesters above the pointer,
  // and wrap to the lowest requester overall when none is found there.
  // x & (~x + 1) isolates the lowest set bit of x.
  assign req_hi       = in_valid & hi_mask;
  assign rr_grant_hi  = req_hi & (~req_hi + NUM_CH'(1));
  assign rr_grant_all = in_valid & (~in_valid + NUM_CH'(1));
  assign rr_grant     = (|req_hi) ? rr_grant_hi : rr_grant_all;

  // Mode is applied combinationally; grant is one-hot or zero in both modes.
  assign grant     = mode ? rr_grant : fix_grant;
  assign grant_any = |grant;

  // Only the granted channel may see ready, and only when the output can load.
  assign in_ready = grant & {NUM_CH{can_load}};
  assign xfer     = grant_any && can_load;

  // One-hot grant to channel index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_idx = grant_idx | SEL_W'(i);
      end
    end
  end

  // AND-OR data mux driven by the one-hot grant
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // A fixed-mode request to a non-existent channel while anyone is waiting
  assign sel_err_next = !mode && !cntl_ok && (|in_valid);

  // Output register: load on transfer, hold under backpressure, drop valid on drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
    end else if (xfer) begin
      out_data_reg  <= sel_data;
      out_valid_reg <= 1'b1;
      out_ch_reg    <= grant_idx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Round-robin pointer moves only on round-robin transfers, so fixed-mode
  // traffic does not disturb fairness when round-robin resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= LAST_INIT;
    end else if (xfer && mode) begin
      last_reg <= grant_idx;
    end
  end

  // Registered single-cycle selection error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= sel_err_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign sel_err   = sel_err_reg;

`ifdef STREAM_MUX_COUNT_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [15:0] cnt_reg;

      // Accepted-transfer counter; clear beats a coincident increment, wraps at 0xFFFF
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (cnt_clr) begin
          cnt_reg <= '0;
        end else if (in_valid[gi] && in_ready[gi]) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign xfer_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (NUM_CH=3, WIDTH=32): a hand-computed
// vector table, hand-written multi-cycle sequences (backpressure, async reset,
// counters when STREAM_MUX_COUNT_EN is defined) and a randomized run checked
// against a behavioural model of the selection rules.
module tb_stream_mux_rr;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int N_RAND = 1500;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        cntl;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;
`ifdef STREAM_MUX_COUNT_EN
  logic                    cnt_clr;
  logic [NUM_CH*16-1:0]    xfer_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .cntl      (cntl),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .sel_err   (sel_err)
`ifdef STREAM_MUX_COUNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  typedef struct {
    logic              mode;
    logic [SEL_W-1:0]  cntl;
    logic [NUM_CH-1:0] valid;
    logic              ordy;
    logic [NUM_CH-1:0] exp_rdy;
    logic              exp_ov;
    logic [SEL_W-1:0]  exp_ch;
    logic [WIDTH-1:0]  exp_data;
    logic              exp_err;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference state
  int          m_last;
  logic        m_ov;
  logic [31:0] m_od;
  int          m_och;
  logic        m_err;
  logic [15:0] m_cnt[NUM_CH];
  logic [31:0] src_data[NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic md, input int c, input logic [NUM_CH-1:0] vl,
                               input logic r, input logic [NUM_CH-1:0] er, input logic eov,
                               input int ech, input logic [31:0] ed, input logic ee);
    vec_t t;
    t.mode = md; t.cntl = SEL_W'(c); t.valid = vl; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_ch = SEL_W'(ech); t.exp_data = ed; t.exp_err = ee;
    return t;
  endfunction

  // Channel chosen by the selection rules, -1 when nobody is granted
  function automatic int model_pick(input logic md, input logic [SEL_W-1:0] c,
                                    input logic [NUM_CH-1:0] v);
    if (!md) begin
      if (int'(c) < NUM_CH) begin
        if (v[c]) return int'(c);
      end
      return -1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (m_last + k) % NUM_CH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < NUM_CH; i++) in_data[i*WIDTH +: WIDTH] = src_data[i];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = '0; mode = 1'b0; cntl = '0; out_ready = 1'b1;
`ifdef STREAM_MUX_COUNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_last = NUM_CH - 1; m_ov = 1'b0; m_od = '0; m_och = 0; m_err = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    src_data[0] = 32'hA; src_data[1] = 32'hB; src_data[2] = 32'hC;
    pack_data();
    do_reset();
    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.out_data", out_data, 32'h0);
    check("reset.out_ch", 32'(out_ch), 32'h0);
    check("reset.sel_err", 32'(sel_err), 32'h0);

    // ---------------- vector table ----------------
    //           mode cntl valid  ordy  exp_rdy ov ch data   err
    vq.push_back(mkv(0, 1, 3'b111, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(0, 1, 3'b111, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(0, 1, 3'b111, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(1, 1, 3'b111, 1, 3'b001, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b100, 1, 2, 32'hC, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b001, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b100, 1, 2, 32'hC, 0));
    vq.push_back(mkv(1, 0, 3'b100, 1, 3'b100, 1, 2, 32'hC, 0));
    vq.push_back(mkv(1, 0, 3'b100, 1, 3'b100, 1, 2, 32'hC, 0));
    vq.push_back(mkv(0, 3, 3'b001, 1, 3'b000, 0, 2, 32'hC, 1));
    vq.push_back(mkv(0, 3, 3'b000, 1, 3'b000, 0, 2, 32'hC, 0));
    vq.push_back(mkv(1, 0, 3'b001, 1, 3'b001, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b010, 0, 3'b000, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b010, 0, 3'b000, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b010, 1, 3'b010, 1, 1, 32'hB, 0));
    vq.push_back(mkv(0, 2, 3'b010, 1, 3'b000, 0, 1, 32'hB, 0));
    vq.push_back(mkv(0, 0, 3'b001, 1, 3'b001, 1, 0, 32'hA, 0));
    vq.push_back(mkv(1, 0, 3'b111, 1, 3'b100, 1, 2, 32'hC, 0));

    foreach (vq[v]) begin
      mode = vq[v].mode; cntl = vq[v].cntl; in_valid = vq[v].valid; out_ready = vq[v].ordy;
      #1;
      check($sformatf("vec%0d.in_ready", v), 32'(in_ready), 32'(vq[v].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.out_valid", v), 32'(out_valid), 32'(vq[v].exp_ov));
      check($sformatf("vec%0d.out_ch", v), 32'(out_ch), 32'(vq[v].exp_ch));
      check($sformatf("vec%0d.out_data", v), out_data, vq[v].exp_data);
      check($sformatf("vec%0d.sel_err", v), 32'(sel_err), 32'(vq[v].exp_err));
      $display("vec %0d: mode=%0d cntl=%0d valid=%b ready=%b -> ov=%0d ch=%0d data=%0h err=%0d",
               v, vq[v].mode, vq[v].cntl, vq[v].valid, in_ready, out_valid, out_ch, out_data, sel_err);
    end

    // ---------------- backpressure: hold 0x55 for 3 cycles ----------------
    do_reset();
    src_data[0] = 32'h55; pack_data();
    mode = 1'b0; cntl = '0; in_valid = 3'b001; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.load_valid", 32'(out_valid), 32'h1);
    check("bp.load_data", out_data, 32'h55);
    src_data[0] = 32'h66; pack_data();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d.in_ready", c), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      check($sformatf("bp%0d.out_valid", c), 32'(out_valid), 32'h1);
      check($sformatf("bp%0d.out_data", c), out_data, 32'h55);
      $display("bp cycle %0d: out_valid=%0d out_data=%0h", c, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    check("bp.next_valid", 32'(out_valid), 32'h1);
    check("bp.next_data", out_data, 32'h66);
    $display("bp release: out_valid=%0d out_data=%0h", out_valid, out_data);

    // ---------------- asynchronous reset mid-cycle ----------------
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("areset.pre_valid", 32'(out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 32'h0);
    check("areset.out_data", out_data, 32'h0);
    check("areset.out_ch", 32'(out_ch), 32'h0);
    $display("async reset: out_valid=%0d out_data=%0h (no clock edge)", out_valid, out_data);
    @(posedge clk); #5;
    reset = 1'b1;
    src_data[0] = 32'hA; src_data[1] = 32'hB; src_data[2] = 32'hC; pack_data();
    mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    check("areset.first_grant", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    check("areset.first_ch", 32'(out_ch), 32'h0);
    check("areset.first_data", out_data, 32'hA);

    // ---------------- randomized run against the model ----------------
    do_reset();
    in_valid = '0;
    for (int t = 0; t < N_RAND; t++) begin
      int g;
      logic [NUM_CH-1:0] exp_rdy;
      logic cl;
      // sources hold valid+data until accepted, otherwise may raise a new word
      for (int i = 0; i < NUM_CH; i++) begin
        if (!in_valid[i] && ($urandom_range(1, 0) == 1)) begin
          in_valid[i] = 1'b1;
          src_data[i] = $urandom;
        end
      end
      pack_data();
      if ($urandom_range(7, 0) == 0) mode = ~mode;
      cntl = SEL_W'($urandom_range(3, 0));
      out_ready = ($urandom_range(3, 0) != 0);
`ifdef STREAM_MUX_COUNT_EN
      cnt_clr = ($urandom_range(31, 0) == 0);
`endif
      #1;
      g = model_pick(mode, cntl, in_valid);
      cl = !m_ov || out_ready;
      exp_rdy = '0;
      if (g >= 0 && cl) exp_rdy[g] = 1'b1;
      check($sformatf("rand%0d.in_ready", t), 32'(in_ready), 32'(exp_rdy));
      @(posedge clk); #1;
      // model update for this edge
      m_err = !mode && (int'(cntl) >= NUM_CH) && (|in_valid);
`ifdef STREAM_MUX_COUNT_EN
      if (cnt_clr) begin
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = '0;
      end else if (g >= 0 && cl) begin
        m_cnt[g] = m_cnt[g] + 16'd1;
      end
`endif
      if (g >= 0 && cl) begin
        m_od = src_data[g]; m_och = g; m_ov = 1'b1;
        if (mode) m_last = g;
        in_valid[g] = 1'b0;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      check($sformatf("rand%0d.out_valid", t), 32'(out_valid), 32'(m_ov));
      check($sformatf("rand%0d.out_data", t), out_data, m_od);
      check($sformatf("rand%0d.out_ch", t), 32'(out_ch), 32'(m_och));
      check($sformatf("rand%0d.sel_err", t), 32'(sel_err), 32'(m_err));
`ifdef STREAM_MUX_COUNT_EN
      for (int i = 0; i < NUM_CH; i++)
        check($sformatf("rand%0d.cnt%0d", t, i), 32'(xfer_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    end

`ifdef STREAM_MUX_COUNT_EN
    // ---------------- transfer counters ----------------
    do_reset();
    mode = 1'b0; cntl = SEL_W'(1); in_valid = 3'b010; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("cnt.five", 32'(xfer_cnt[16 +: 16]), 32'd5);
    check("cnt.ch0_idle", 32'(xfer_cnt[0 +: 16]), 32'd0);
    cnt_clr = 1'b1;
    #1;
    check("cnt.sixth_ready", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    check("cnt.cleared", 32'(xfer_cnt[16 +: 16]), 32'd0);
    $display("counter clear with coincident transfer: cnt1=%0d", xfer_cnt[16 +: 16]);
    cnt_clr = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check("cnt.max", 32'(xfer_cnt[16 +: 16]), 32'hFFFF);
    @(posedge clk); #1;
    check("cnt.wrap", 32'(xfer_cnt[16 +: 16]), 32'd0);
    $display("counter wrap: cnt1=%0h", xfer_cnt[16 +: 16]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
